// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for the iterative multiplier.
// The source-and-sink side uses master; the multiplier uses slave.
interface seq_multiplier_if #(
    parameter int DATAWIDTH = 14
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     signed_mode;
    logic [DATAWIDTH-1:0]     multi1;
    logic [DATAWIDTH-1:0]     multi2;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*DATAWIDTH-1:0]   product;
    logic                     busy;

    modport master (
        output in_valid, signed_mode, multi1, multi2, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, signed_mode, multi1, multi2, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one multiplier bit per cycle on sign-stripped magnitudes,
// with the sign restored on the final step. Valid/ready on both sides.
module seq_multiplier #(
    parameter int DATAWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst,
    seq_multiplier_if.slave   bus
);
    localparam int PW    = 2 * DATAWIDTH;
    localparam int CNT_W = $clog2(DATAWIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PW-1:0]        mcand;
    logic [DATAWIDTH-1:0] mplier;
    logic [PW-1:0]        acc;
    logic [PW-1:0]        acc_sum;
    logic [PW-1:0]        product_r;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 accept;
    logic                 last_bit;

    // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1), which still fits unsigned.
    function automatic logic [DATAWIDTH-1:0] magnitude(
        input logic signed [DATAWIDTH-1:0] v,
        input logic                        sm
    );
        logic [DATAWIDTH-1:0] u;
        u = v;
        return (sm && u[DATAWIDTH-1]) ? (~u + 1'b1) : u;
    endfunction

    function automatic logic signed [PW-1:0] apply_sign(
        input logic [PW-1:0] mag,
        input logic          n
    );
        return n ? signed'(~mag + 1'b1) : signed'(mag);
    endfunction

    assign accept   = bus.in_valid && (state == IDLE);
    assign last_bit = (cnt == CNT_W'(DATAWIDTH - 1));
    assign acc_sum  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = CALC;
            CALC:    if (last_bit)      state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right, so bit cnt is always mplier[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            product_r <= '0;
        end else if (accept) begin
            mcand  <= {{DATAWIDTH{1'b0}}, magnitude(bus.multi1, bus.signed_mode)};
            mplier <= magnitude(bus.multi2, bus.signed_mode);
            neg    <= bus.signed_mode & (bus.multi1[DATAWIDTH-1] ^ bus.multi2[DATAWIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_bit) product_r <= apply_sign(acc_sum, neg);
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.product   = product_r;
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed bench for seq_multiplier against a plain-arithmetic
// product model, with backpressure, ignored-input and mid-operation reset cases.
module tb_seq_multiplier;
    localparam int DW = 14;
    localparam int PW = 2 * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    seq_multiplier_if #(.DATAWIDTH(DW)) bus ();

    seq_multiplier #(.DATAWIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic sm);
        longint x, y, p;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[PW-1:0];
    endfunction

    task automatic check_idle_reset_values(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"},      64'(bus.busy),      64'd0);
        chk({tag, "_product"},   64'(bus.product),   64'd0);
    endtask

    // gap < 0: out_ready held high from accept; otherwise held low for gap cycles
    // after out_valid. Junk operands are driven with in_valid high while busy.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sm,
                          input int gap, output logic [PW-1:0] got);
        int lat;
        int w;
        @(negedge clk);
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_valid    = 1'b1;
        bus.multi1      = a;
        bus.multi2      = b;
        bus.signed_mode = sm;
        bus.out_ready   = (gap < 0);
        @(posedge clk);
        #1;
        bus.multi1      = ~a;
        bus.multi2      = b ^ DW'(14'h1555);
        bus.signed_mode = ~sm;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(DW));
        got = bus.product;
        if (gap < 0) begin
            @(posedge clk);
            #1;
            chk("pulse_one_cycle", 64'(bus.out_valid), 64'd0);
        end else begin
            for (int i = 0; i < gap; i++) begin
                bus.in_valid = (i % 3 == 0);
                @(posedge clk);
                #1;
                chk("hold_valid",   64'(bus.out_valid), 64'd1);
                chk("hold_product", 64'(bus.product),   64'(got));
                chk("hold_ready",   64'(bus.in_ready),  64'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            chk("after_hs_valid", 64'(bus.out_valid), 64'd0);
        end
        chk("after_hs_ready",   64'(bus.in_ready), 64'd1);
        chk("after_hs_busy",    64'(bus.busy),     64'd0);
        chk("after_hs_product", 64'(bus.product),  64'(got));
    endtask

    initial begin
        logic [PW-1:0] got;
        logic [DW-1:0] a, b;
        logic          sm;
        int            gap;

        bus.in_valid    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.multi1      = '0;
        bus.multi2      = '0;
        bus.out_ready   = 1'b0;
        #2;
        check_idle_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle_reset_values("post_reset");

        run_op(14'd255, 14'd4, 1'b0, -1, got);
        chk("u_255x4", 64'(got), 64'd1020);
        run_op(14'h3FFF, 14'h3FFF, 1'b0, 0, got);
        chk("u_max", 64'(got), 64'h0FFF8001);
        run_op(14'h3FFF, 14'h0004, 1'b1, 1, got);
        chk("s_m1x4", 64'(got), 64'h0FFFFFFC);
        run_op(14'h2000, 14'h2000, 1'b1, 0, got);
        chk("s_minxmin", 64'(got), 64'h04000000);
        run_op(14'h2000, 14'h2000, 1'b0, -1, got);
        chk("u_8192sq", 64'(got), 64'h04000000);
        run_op(14'h2000, 14'h1FFF, 1'b1, 2, got);
        chk("s_minxmax", 64'(got), 64'h0C002000);
        run_op(14'd0, 14'd0, 1'b1, 0, got);
        chk("zero", 64'(got), 64'd0);

        run_op(14'd1234, 14'h3F00, 1'b1, 20, got);
        chk("backpressure", 64'(got), 64'(ref_mul(14'd1234, 14'h3F00, 1'b1)));
        run_op(14'd77, 14'd99, 1'b0, -1, got);
        chk("back_to_back", 64'(got), 64'd7623);

        // Reset asserted between edges 5 cycles into CALC.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.multi1      = 14'd500;
        bus.multi2      = 14'd600;
        bus.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check_idle_reset_values("mid_calc_rst");
        @(negedge clk);
        rst = 1'b0;
        run_op(14'd3, 14'd5, 1'b0, 0, got);
        chk("after_rst_3x5", 64'(got), 64'd15);

        for (int n = 0; n < 2000; n++) begin
            a   = DW'($urandom);
            b   = DW'($urandom);
            sm  = 1'($urandom);
            gap = int'($urandom_range(0, 4)) - 1;
            run_op(a, b, sm, gap, got);
            chk("random", 64'(got), 64'(ref_mul(a, b, sm)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
